// File: rtl/lsf_lsp_conv_if.sv
`default_nettype none
// ============================================================================
// Module   : lsf_lsp_conv_if
// Desc     : Start/config and memory-port bundle for the LSF->LSP converter.
// Revision : 1.0  initial release
// ============================================================================
interface lsf_lsp_conv_if #(
  parameter int ADDR_W = 12
);
  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] lsfAddr;
  logic [ADDR_W-1:0] lspAddr;
  logic [31:0]       memIn;
  logic [31:0]       constMemIn;
  logic [ADDR_W-1:0] memReadAddr;
  logic [ADDR_W-1:0] constMemAddr;
  logic [ADDR_W-1:0] memWriteAddr;
  logic [31:0]       memOut;
  logic              memWriteEn;
  logic              busy;
  logic              done;

  modport master (
    output start, mode, lsfAddr, lspAddr, memIn, constMemIn,
    input  memReadAddr, constMemAddr, memWriteAddr, memOut, memWriteEn, busy, done
  );

  modport slave (
    input  start, mode, lsfAddr, lspAddr, memIn, constMemIn,
    output memReadAddr, constMemAddr, memWriteAddr, memOut, memWriteEn, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/lsf_lsp_conv.sv
`default_nettype none
// ============================================================================
// Module   : lsf_lsp_conv
// Desc     : LSF->LSP converter using cosine-table interpolation (G.729 modes).
// Revision : 1.0  initial release
// ============================================================================
module lsf_lsp_conv #(
  parameter int M           = 10,
  parameter int ADDR_W      = 12,
  parameter int TABLE2_BASE = 'h000,
  parameter int SLOPE_BASE  = 'h040,
  parameter int TABLE_BASE  = 'h080
) (
  input  logic          clk,
  input  logic          reset,
  lsf_lsp_conv_if.slave bus
);

  localparam logic [2:0] c_S_IDLE  = 3'd0;
  localparam logic [2:0] c_S_FETCH = 3'd1;
  localparam logic [2:0] c_S_IDX   = 3'd2;
  localparam logic [2:0] c_S_TAB   = 3'd3;
  localparam logic [2:0] c_S_WR    = 3'd4;
  localparam logic [2:0] c_S_DONE  = 3'd5;

  localparam logic [4:0] c_LAST = 5'(M - 1);

  logic [2:0]        r_state;
  logic [4:0]        r_i;
  logic              r_mode;
  logic [ADDR_W-1:0] r_lsf_addr;
  logic [ADDR_W-1:0] r_lsp_addr;
  logic [5:0]        r_ind;
  logic [7:0]        r_off;
  logic signed [15:0] r_a;

  function automatic logic signed [15:0] f_sat16(input logic signed [16:0] v);
    if (v > 17'sd32767)       return 16'sh7fff;
    else if (v < -17'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

  function automatic logic signed [15:0] f_add16(input logic signed [15:0] a,
                                                 input logic signed [15:0] b);
    return f_sat16({a[15], a} + {b[15], b});
  endfunction

  function automatic logic signed [15:0] f_sub16(input logic signed [15:0] a,
                                                 input logic signed [15:0] b);
    return f_sat16({a[15], a} - {b[15], b});
  endfunction

  // Only (-32768)*(-32768) overflows once doubled.
  function automatic logic signed [31:0] f_l_mult(input logic signed [15:0] p,
                                                  input logic signed [15:0] q);
    logic signed [31:0] prod;
    prod = {{16{p[15]}}, p} * {{16{q[15]}}, q};
    if (p == 16'sh8000 && q == 16'sh8000) return 32'sh7fffffff;
    return prod <<< 1;
  endfunction

  logic signed [31:0] w_x_ext;
  logic signed [31:0] w_f;
  logic signed [15:0] w_sel;
  logic signed [15:0] w_ind_raw;
  logic [5:0]         w_ind;
  logic [7:0]         w_off;

  always_comb begin
    w_x_ext   = {{16{bus.memIn[15]}}, bus.memIn[15:0]};
    w_f       = (w_x_ext * 32'sd20861) >>> 15;
    w_sel     = r_mode ? w_x_ext[15:0] : w_f[15:0];
    w_ind_raw = w_sel >>> 8;
    w_off     = w_sel[7:0];
    if (w_ind_raw > 16'sd63)     w_ind = 6'd63;
    else if (w_ind_raw < 16'sd0) w_ind = 6'd0;
    else                         w_ind = w_ind_raw[5:0];
  end

  logic signed [15:0] w_b;
  logic signed [15:0] w_d;
  logic signed [31:0] w_l;
  logic signed [15:0] w_y;

  always_comb begin
    w_b = bus.constMemIn[15:0];
    w_d = f_sub16(r_a, w_b);
    w_l = f_l_mult(r_mode ? w_d : r_a, {8'd0, r_off});
    w_y = r_mode ? f_add16(w_b, w_l[24:9]) : f_add16(w_b, w_l[28:13]);
  end

  logic w_unused;
  assign w_unused = ^{bus.memIn[31:16], bus.constMemIn[31:16], w_f[31:16],
                      w_l[31:29], w_l[8:0]};

  // Address/strobe outputs are decoded from state so they are zero outside their slot.
  always_comb begin
    bus.memReadAddr  = '0;
    bus.constMemAddr = '0;
    bus.memWriteAddr = '0;
    bus.memOut       = '0;
    bus.memWriteEn   = 1'b0;
    bus.busy         = (r_state != c_S_IDLE);
    bus.done         = (r_state == c_S_DONE);
    case (r_state)
      c_S_FETCH: bus.memReadAddr = r_lsf_addr + ADDR_W'(r_i);
      c_S_IDX: begin
        if (r_mode)
          bus.constMemAddr = ADDR_W'(TABLE_BASE) + ADDR_W'(w_ind) + ADDR_W'(1);
        else
          bus.constMemAddr = ADDR_W'(SLOPE_BASE) + ADDR_W'(w_ind);
      end
      c_S_TAB: begin
        if (r_mode)
          bus.constMemAddr = ADDR_W'(TABLE_BASE) + ADDR_W'(r_ind);
        else
          bus.constMemAddr = ADDR_W'(TABLE2_BASE) + ADDR_W'(r_ind);
      end
      c_S_WR: begin
        bus.memWriteAddr = r_lsp_addr + ADDR_W'(r_i);
        bus.memOut       = {{16{w_y[15]}}, w_y};
        bus.memWriteEn   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= c_S_IDLE;
      r_i        <= '0;
      r_mode     <= 1'b0;
      r_lsf_addr <= '0;
      r_lsp_addr <= '0;
      r_ind      <= '0;
      r_off      <= '0;
      r_a        <= '0;
    end else begin
      case (r_state)
        c_S_IDLE: begin
          if (bus.start) begin
            r_mode     <= bus.mode;
            r_lsf_addr <= bus.lsfAddr;
            r_lsp_addr <= bus.lspAddr;
            r_i        <= '0;
            r_state    <= c_S_FETCH;
          end
        end
        c_S_FETCH: r_state <= c_S_IDX;
        c_S_IDX: begin
          r_ind   <= w_ind;
          r_off   <= w_off;
          r_state <= c_S_TAB;
        end
        c_S_TAB: begin
          r_a     <= bus.constMemIn[15:0];
          r_state <= c_S_WR;
        end
        c_S_WR: begin
          r_i     <= r_i + 5'd1;
          r_state <= (r_i == c_LAST) ? c_S_DONE : c_S_FETCH;
        end
        c_S_DONE: begin
          r_i     <= '0;
          r_state <= c_S_IDLE;
        end
        default: r_state <= c_S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsf_lsp_conv.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsf_lsp_conv
// Desc     : Directed bench for lsf_lsp_conv with data/constant memory models.
// Revision : 1.0  initial release
// ============================================================================
module tb_lsf_lsp_conv;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lsf_lsp_conv_if #(.ADDR_W(12)) bus ();

  lsf_lsp_conv #(
    .M(10), .ADDR_W(12), .TABLE2_BASE('h000), .SLOPE_BASE('h040), .TABLE_BASE('h080)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [31:0] dmem [0:4095];
  logic [15:0] cmem [0:4095];
  logic        ld_en;
  logic [11:0] ld_addr;
  logic [31:0] ld_data;

  int cyc = 0;
  int nvec = 0;
  int nfail = 0;

  int wr_addr_q[$];
  int wr_data_q[$];
  int wr_cyc_q[$];
  int done_q[$];
  int rise_q[$];
  int fall_q[$];
  logic busy_d = 1'b0;

  int a_lsf[10] = '{12868, 12900, 32767, 2043, 100, -5, 0, 256, -32768, 16384};
  int a_exp[10] = '{12800, 12797, 25184, 32767, -8, -32, 0, -21, -17, 15976};
  int b_lsf[10] = '{8300, -5, 0, 32767, 16384, 256, 511, 16383, -32768, 1000};
  int b_exp[10] = '{16210, 490, 0, 31998, 31500, 500, 998, 31998, 0, 1953};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.memIn      <= dmem[bus.memReadAddr];
    bus.constMemIn <= {16'hA5A5, cmem[bus.constMemAddr]};
    if (bus.memWriteEn) dmem[bus.memWriteAddr] <= bus.memOut;
    if (ld_en) dmem[ld_addr] <= ld_data;
  end

  always @(negedge clk) begin
    if (bus.memWriteEn) begin
      wr_addr_q.push_back(int'(bus.memWriteAddr));
      wr_data_q.push_back(int'(bus.memOut));
      wr_cyc_q.push_back(cyc);
    end
    if (bus.done) done_q.push_back(cyc);
    if (bus.busy && !busy_d) rise_q.push_back(cyc);
    if (!bus.busy && busy_d) fall_q.push_back(cyc - 1);
    busy_d <= bus.busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qget(input int q[$], input int idx);
    if (idx < q.size()) return 32'(q[idx]);
    return 32'hxxxxxxxx;
  endfunction

  task automatic load(input logic [11:0] a, input logic [31:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  32'(bus.busy), 0);
    check({tag, "_done"},  32'(bus.done), 0);
    check({tag, "_wen"},   32'(bus.memWriteEn), 0);
    check({tag, "_raddr"}, 32'(bus.memReadAddr), 0);
    check({tag, "_caddr"}, 32'(bus.constMemAddr), 0);
    check({tag, "_waddr"}, 32'(bus.memWriteAddr), 0);
    check({tag, "_mout"},  bus.memOut, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c0b, c0c, c0d, wb, db, rb, fb, wb2, db2, wb3, db3;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.mode    = 1'b0;
    bus.lsfAddr = '0;
    bus.lspAddr = '0;
    ld_en       = 1'b0;
    ld_addr     = '0;
    ld_data     = '0;
    for (int k = 0; k < 4096; k++) cmem[k] = 16'h0000;
    for (int k = 0; k < 64; k++) begin
      cmem['h000 + k] = 16'(400 * k);
      cmem['h040 + k] = 16'hFE00;
    end
    for (int k = 0; k <= 64; k++) cmem['h080 + k] = 16'(500 * k);
    cmem['h005] = 16'h7FFF;
    cmem['h045] = 16'h7FFF;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      load(12'('h100 + i), {16'h5A5A, 16'(a_lsf[i])});
      load(12'('h400 + i), {16'h5A5A, 16'(b_lsf[i])});
      load(12'('hFFC + i), {16'h5A5A, 16'(b_lsf[i])});
    end
    ld_en = 1'b0;
    @(negedge clk);
    check_idle_outputs("idle");

    // Run A (mode 0) with start held high; run B (mode 1, in place) follows back-to-back.
    wb = wr_addr_q.size(); db = done_q.size(); rb = rise_q.size(); fb = fall_q.size();
    c0 = cyc;
    bus.start = 1'b1; bus.mode = 1'b0; bus.lsfAddr = 12'h100; bus.lspAddr = 12'h200;
    @(negedge clk);
    check("a_busy_c1", 32'(bus.busy), 1);
    check("a_raddr_c1", 32'(bus.memReadAddr), 'h100);
    bus.mode = 1'b1; bus.lsfAddr = 12'h400; bus.lspAddr = 12'h400;
    repeat (40) @(negedge clk);
    check("a_done_c41", 32'(bus.done), 1);
    @(negedge clk);
    check("a_busy_c42", 32'(bus.busy), 0);
    check("a_done_c42", 32'(bus.done), 0);
    c0b = c0 + 42;
    @(negedge clk);
    bus.start = 1'b0;
    check("b_busy_c1", 32'(bus.busy), 1);
    check("b_raddr_c1", 32'(bus.memReadAddr), 'h400);
    repeat (40) @(negedge clk);
    check("b_done_c41", 32'(bus.done), 1);
    repeat (3) @(negedge clk);

    check("ab_nwrites", 32'(wr_addr_q.size() - wb), 20);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("a_waddr%0d", i), qget(wr_addr_q, wb + i), 32'('h200 + i));
      check($sformatf("a_wdata%0d", i), qget(wr_data_q, wb + i), 32'(a_exp[i]));
      check($sformatf("a_wcyc%0d", i),  qget(wr_cyc_q, wb + i), 32'(c0 + 4 + 4 * i));
      check($sformatf("b_waddr%0d", i), qget(wr_addr_q, wb + 10 + i), 32'('h400 + i));
      check($sformatf("b_wdata%0d", i), qget(wr_data_q, wb + 10 + i), 32'(b_exp[i]));
      check($sformatf("b_wcyc%0d", i),  qget(wr_cyc_q, wb + 10 + i), 32'(c0b + 4 + 4 * i));
    end
    check("ab_ndone", 32'(done_q.size() - db), 2);
    check("a_done_cyc", qget(done_q, db), 32'(c0 + 41));
    check("b_done_cyc", qget(done_q, db + 1), 32'(c0b + 41));
    check("a_busy_rise", qget(rise_q, rb), 32'(c0 + 1));
    check("a_busy_last", qget(fall_q, fb), 32'(c0 + 41));
    check("b_busy_rise", qget(rise_q, rb + 1), 32'(c0b + 1));
    check("b_busy_last", qget(fall_q, fb + 1), 32'(c0b + 41));

    // Run C aborted by reset in cycle 9.
    wb2 = wr_addr_q.size(); db2 = done_q.size();
    c0c = cyc;
    bus.start = 1'b1; bus.mode = 1'b1; bus.lsfAddr = 12'hFFC; bus.lspAddr = 12'hFF8;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    check("c_cycle9", 32'(cyc - c0c), 9);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle_outputs("c_postreset");
    repeat (50) @(negedge clk);
    check("c_nwrites", 32'(wr_addr_q.size() - wb2), 2);
    check("c_ndone", 32'(done_q.size() - db2), 0);
    check("c_waddr0", qget(wr_addr_q, wb2), 'hFF8);
    check("c_waddr1", qget(wr_addr_q, wb2 + 1), 'hFF9);

    // Run D: restart after abort, addresses wrap modulo 2^12.
    wb3 = wr_addr_q.size(); db3 = done_q.size();
    c0d = cyc;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("d_raddr_c1", 32'(bus.memReadAddr), 'hFFC);
    repeat (44) @(negedge clk);
    check("d_nwrites", 32'(wr_addr_q.size() - wb3), 10);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("d_waddr%0d", i), qget(wr_addr_q, wb3 + i), 32'(12'('hFF8 + i)));
      check($sformatf("d_wdata%0d", i), qget(wr_data_q, wb3 + i), 32'(b_exp[i]));
    end
    check("d_wcyc0", qget(wr_cyc_q, wb3), 32'(c0d + 4));
    check("d_done_cyc", qget(done_q, db3), 32'(c0d + 41));
    check_idle_outputs("end");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire
